serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder: computes A + B + CIN one bit per clock, LSB first, with a
// single full-adder stage and a 1-bit carry register. A WIDTH-bit addition
// occupies WIDTH cycles in RUN, followed by one FIN cycle in which DONE is
// high and SUM/COUT present the freshly completed result.
//
// Parameters
//   WIDTH  operand and sum width in bits (2..32)
//
// Ports
//   CLK    in   1      clock, all state updates on the rising edge
//   RST    in   1      synchronous active-high reset
//   START  in   1      request an addition (accepted in IDLE or FIN)
//   A      in   WIDTH  operand A, sampled on the accepting edge
//   B      in   WIDTH  operand B, sampled on the accepting edge
//   CIN    in   1      carry-in, sampled on the accepting edge
//   SUM    out  WIDTH  registered (A+B+CIN) mod 2^WIDTH
//   COUT   out  1      registered carry-out of the last addition
//   BUSY   out  1      high while in RUN
//   DONE   out  1      one-cycle pulse (the FIN cycle) marking a new result
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             BUSY,
    output logic             DONE
);

    // Counter must be able to hold WIDTH (it increments past WIDTH-1 on the
    // final RUN edge and simply holds there until the next acceptance).
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Full-adder sum bit.
    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    // Full-adder carry (majority) bit.
    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t           state_r;
    state_t           state_s;

    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;

    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;

    logic             busy_s;
    logic             done_s;
    logic             accept_s;
    logic             last_s;
    logic             bit_sum_s;
    logic             bit_carry_s;

    // One full-adder stage working on the current LSBs and the carry register.
    always_comb begin
        bit_sum_s   = fa_sum(a_sh_r[0], b_sh_r[0], carry_r);
        bit_carry_s = fa_carry(a_sh_r[0], b_sh_r[0], carry_r);
    end

    // START is honoured only when no addition is running; last_s marks the
    // WIDTH-th RUN edge (counter already holds WIDTH-1 before it).
    always_comb begin
        accept_s = START && ((state_r == IDLE) || (state_r == FIN));
        last_s   = (state_r == RUN) && (cnt_r == CW'(WIDTH - 1));
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic. FIN can chain straight into RUN so that a held
    // START yields back-to-back additions every WIDTH+1 cycles.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = FIN;
                end else begin
                    state_s = RUN;
                end
            end
            FIN: begin
                if (accept_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM output decode, taken from the next state so that the flopped
    // BUSY/DONE line up exactly with the RUN/FIN states.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_s)
            IDLE: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
            RUN: begin
                busy_s = 1'b1;
                done_s = 1'b0;
            end
            FIN: begin
                busy_s = 1'b0;
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Status flags as registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

    // Serial datapath: operands shift right so bit 0 is always the bit being
    // added; result bits enter at the MSB so after WIDTH shifts the LSB of the
    // sum has arrived at bit 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            res_r   <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
        end else if (accept_s) begin
            a_sh_r  <= A;
            b_sh_r  <= B;
            res_r   <= '0;
            carry_r <= CIN;
            cnt_r   <= '0;
        end else if (state_r == RUN) begin
            a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
            b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
            res_r   <= {bit_sum_s, res_r[WIDTH-1:1]};
            carry_r <= bit_carry_s;
            cnt_r   <= cnt_r + CW'(1);
        end else begin
            a_sh_r  <= a_sh_r;
            b_sh_r  <= b_sh_r;
            res_r   <= res_r;
            carry_r <= carry_r;
            cnt_r   <= cnt_r;
        end
    end

    // Visible result: updated only on the FIN-entry edge, straight from the
    // adder stage so the final bit does not need to pass through res_r first.
    // An aborted operation therefore never reaches SUM.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else if (last_s) begin
            sum_r  <= {bit_sum_s, res_r[WIDTH-1:1]};
            cout_r <= bit_carry_s;
        end else begin
            sum_r  <= sum_r;
            cout_r <= cout_r;
        end
    end

    assign SUM  = sum_r;
    assign COUT = cout_r;
    assign BUSY = busy_r;
    assign DONE = done_r;

endmodule
